scan_frame_sched: RTL

- Single-clock sequencer for the pressure-matrix scan.
- Steps the row/column demux address and issues ADC conversion starts.
- Waits for either ADC data-ready, captures each 8-bit sample and packs a full matrix frame (head byte, samples, tail byte) into a small FIFO.
- The FIFO feeds the UART transmitter through a valid/ready handshake. Replaces negedge-of-DRDY clocking with logic fully synchronous to `clock`.

---
 rtl/scan_frame_sched_if.sv | 10 +
 rtl/scan_frame_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_frame_sched_if.sv
// Byte stream from the frame scheduler FIFO to the UART transmitter.
// The master drives data/valid; the slave answers with ready.
interface scan_frame_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/scan_frame_sched.sv
// Pressure-matrix scan sequencer: steps the demux address, starts ADC conversions,
// captures samples on a synchronised DRDY edge and queues framed bytes for the UART.
module scan_frame_sched #(
  parameter int unsigned DIMX       = 14,
  parameter int unsigned DIMY       = 31,
  parameter int unsigned SETTLE     = 64,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  HEAD_BYTE  = 8'hFF,
  parameter logic [7:0]  TAIL_BYTE  = 8'hFE
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               config_done_i,
  input  logic               enable_i,
  input  logic               n_DRDY1_i,
  input  logic               n_DRDY2_i,
  input  logic [7:0]         adc_data_i,
  output logic               adc_start_o,
  output logic [4:0]         deMUX_X_o,
  output logic [4:0]         deMUX_Y_o,
  output logic               frame_busy_o,
  output logic               timeout_err_o,
  output logic [15:0]        frame_count_o,
  scan_frame_sched_if.master tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT) + 1;
  localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_SETTLE, S_WAIT, S_CAPTURE, S_ADVANCE, S_TAIL
  } state_t;

  state_t        state_q;
  logic [4:0]    x_q, y_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sample_q;
  logic          adc_start_q, frame_busy_q, timeout_err_q;
  logic [15:0]   frame_count_q;

  logic [1:0]    drdy1_sync_q, drdy2_sync_q;
  logic          drdy_q;
  logic          drdy, drdy_rise;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          tx_valid_q;
  logic          push_req, push, pop;
  logic [7:0]    push_data;

  // Either ADC pulling its DRDY low raises drdy; sync flops idle high (not ready).
  assign drdy      = !(drdy1_sync_q[1] & drdy2_sync_q[1]);
  assign drdy_rise = drdy & !drdy_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      drdy1_sync_q <= 2'b11;
      drdy2_sync_q <= 2'b11;
      drdy_q       <= 1'b0;
    end else begin
      drdy1_sync_q <= {drdy1_sync_q[0], n_DRDY1_i};
      drdy2_sync_q <= {drdy2_sync_q[0], n_DRDY2_i};
      drdy_q       <= drdy;
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop  = tx_valid_q & tx.tx_ready;
  assign push = push_req & ((count_q != FIFO_FULL) | pop);

  always_comb begin
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    push_req  = 1'b0;
    push_data = HEAD_BYTE;
    case (state_q)
      S_HEAD:    push_req = 1'b1;
      S_CAPTURE: begin
        push_req  = 1'b1;
        push_data = (sample_q >= 8'hFE) ? 8'hFD : sample_q;
      end
      S_TAIL: begin
        push_req  = 1'b1;
        push_data = TAIL_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q    <= count_d;
      tx_valid_q <= (count_d != '0);
    end
  end

  assign tx.tx_data  = fifo_mem_q[rd_ptr_q];
  assign tx.tx_valid = tx_valid_q;

  // cnt_q times the settle delay, then is reused as the DRDY timeout timer.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      sample_q      <= '0;
      adc_start_q   <= 1'b0;
      frame_busy_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      adc_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (config_done_i & enable_i) state_q <= S_HEAD;
        end
        S_HEAD: begin
          x_q          <= '0;
          y_q          <= '0;
          frame_busy_q <= 1'b1;
          if (push) begin
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE - 1)) begin
            cnt_q       <= '0;
            adc_start_q <= 1'b1;
            state_q     <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (drdy_rise) begin
            sample_q <= adc_data_i;
            state_q  <= S_CAPTURE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            sample_q      <= 8'h00;
            timeout_err_q <= 1'b1;
            state_q       <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_CAPTURE: begin
          if (push) state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          cnt_q <= '0;
          if (x_q < 5'(DIMX)) begin
            x_q     <= x_q + 5'd1;
            state_q <= S_SETTLE;
          end else if (y_q < 5'(DIMY)) begin
            x_q     <= '0;
            y_q     <= y_q + 5'd1;
            state_q <= S_SETTLE;
          end else begin
            state_q <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (push) begin
            frame_count_q <= frame_count_q + 16'd1;
            frame_busy_q  <= 1'b0;
            state_q       <= enable_i ? S_HEAD : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_start_o   = adc_start_q;
  assign deMUX_X_o     = x_q;
  assign deMUX_Y_o     = y_q;
  assign frame_busy_o  = frame_busy_q;
  assign timeout_err_o = timeout_err_q;
  assign frame_count_o = frame_count_q;

endmodule
